rmii_rx_deserializer: RTL and testbench
=======================================

// Module: rmii_rx_deserializer
// PURPOSE
//  RMII receive front end for the ethernet subsystem: turns PHY dibits (CRS_DV, RXD[1:0], RX_ER) on
//  the 50 MHz RMII reference clock into MII nibbles, RX_DV, RX_ER, CRS and a derived RX clock.
//  Sits between the board RMII pins and the MAC's MII receive port.
//  Handles nibble alignment, CRS_DV end-of-frame toggling, false carrier and 10/100 decimation.
// PARAMETERS
//  TICK_DIV      10  ref_clk cycles per dibit at 10 Mb/s (valid 2..15)
//  SAMPLE_PHASE  5   decimation count value at which a dibit is sampled at 10 Mb/s (< TICK_DIV)
// PORTS
//  ref_clk          in   1  RMII reference clock, 50 MHz; only clock
//  rst_n            in   1  synchronous, active-low reset
//  speed_100        in   1  1 = 100 Mb/s, 0 = 10 Mb/s; change only while crs_dv low
//  phy2rmii_crs_dv  in   1  RMII CRS_DV
//  phy2rmii_rxd     in   2  RMII RXD, bit 0 first on wire
//  phy2rmii_rx_er   in   1  RMII RX_ER
//  rmii2mac_rx_clk  out  1  MII RX clock: 25 MHz (100M) / 2.5 MHz (10M), 50% duty, free-running
//  rmii2mac_rxd     out  4  MII RXD nibble
//  rmii2mac_rx_dv   out  1  MII RX_DV
//  rmii2mac_rx_er   out  1  MII RX_ER
//  rmii2mac_crs     out  1  carrier sense
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, tick counter 0, phase bit 0, crs_dv history = 1.
//  - Tick: 100M every cycle; 10M when counter == SAMPLE_PHASE (counter wraps TICK_DIV-1 -> 0).
//    All sampling below happens on ticks only.
//  - Phase bit ph toggles every tick; rmii2mac_rx_clk = ph (registered). MII outputs update only on
//    ticks where ph goes 1->0 (falling rx_clk), so MAC samples stable data on rising rx_clk.
//  - States: IDLE -> PREAMBLE -> DATA -> IDLE.
//    IDLE: start only on crs_dv rising edge (low on previous tick, high now); frame in progress at
//      reset release is ignored until crs_dv seen low. crs = 1 from first high sample.
//    PREAMBLE: rxd 00 -> stay; rxd 01 -> DATA, this dibit = first (low) dibit of nibble;
//      rxd 10 -> false carrier: rx_er=1, rxd=4'hE, rx_dv=0 until crs_dv low, then IDLE;
//      crs_dv low -> IDLE, no nibble emitted.
//    DATA: dibits paired first->rxd[1:0], second->rxd[3:0]'s [3:2]; rx_er of nibble = OR of both.
//      crs_dv sampled on first dibit drives crs (low = carrier gone, data continues).
//      crs_dv low on second dibit = end of frame: partial/last-dibit data discarded, -> IDLE,
//      rx_dv deasserts at next output update. Low on both dibits also ends frame.
//  - Completed nibble held in a one-entry buffer and presented at next output update with rx_dv=1;
//    latency second-dibit tick -> output = 1 or 2 ticks (+1 cycle register).
//  - Nibble buffer overwrite impossible (one nibble per two ticks); rx_dv gaps never occur mid-frame.
//  - Simultaneous crs_dv fall and rx_er: rx_er reported on the last emitted nibble only if it was
//    sampled with a paired second dibit; otherwise dropped.
//  - Reset mid-frame: outputs 0 on the next edge, frame discarded; speed change mid-frame: undefined.
// CONFIGURATION
//  RMII_RX_10M_EN defined: speed_100 honoured, decimation counter present.
//  Not defined: fixed 100 Mb/s, speed_100 ignored, counter and both parameters unused.
// TESTING
//  1. 100M: 7x 0x55, 0xD5, 0xA1, 0x3C, then crs_dv low -> rx_dv nibbles 5 x14, 5, D, 1, A, C, 3;
//     rx_dv falls after 3; rx_clk 25 MHz throughout.
//  2. 100M end toggling: after last byte, crs_dv low/high on first/second dibits for 2 nibbles
//     carrying 0xFF -> crs drops at first toggle, nibbles F, F still delivered, then rx_dv=0.
//  3. False carrier: crs_dv=1, rxd=10 before any 01 -> rxd=E, rx_er=1, rx_dv=0 until crs_dv low.
//  4. 10M (macro on, speed_100=0): each dibit held 10 cycles, frame of test 1 -> same nibbles,
//     rx_clk period 20 cycles, no duplicate nibbles.
//  5. rst_n low for 1 cycle mid-DATA, crs_dv stays high -> outputs 0, no nibbles until crs_dv
//     low then new frame; new frame decoded correctly.
//  6. rx_er=1 on second dibit of byte 0x77 -> nibble 7 with rx_er=1, adjacent nibbles rx_er=0.

Source files
------------

// File: rtl/rmii_rx_deserializer.sv
// -----------------------------------------------------------------------------
// rmii_rx_deserializer
//
// RMII receive front end. Converts the PHY dibit stream (CRS_DV, RXD[1:0],
// RX_ER), sampled on the 50 MHz RMII reference clock, into an MII receive
// interface: 4-bit nibbles with RX_DV, RX_ER, CRS and a derived RX clock.
// Handles nibble alignment on the first 01 dibit of the preamble, the CRS_DV
// end-of-frame toggling, false-carrier indication and 10 Mb/s decimation.
//
// Build option: define RMII_RX_10M_EN to honour speed_100 and include the
// 10 Mb/s decimation counter. Without it the block runs at 100 Mb/s only,
// speed_100 is ignored and TICK_DIV / SAMPLE_PHASE have no effect.
//
// Parameters
//   TICK_DIV        ref_clk cycles per dibit at 10 Mb/s (2..15)
//   SAMPLE_PHASE    counter value at which a 10 Mb/s dibit is sampled
//
// Ports
//   ref_clk          in   RMII reference clock (only clock)
//   rst_n            in   synchronous active-low reset
//   speed_100        in   1 = 100 Mb/s, 0 = 10 Mb/s (change only while idle)
//   phy2rmii_crs_dv  in   RMII CRS_DV
//   phy2rmii_rxd     in   RMII RXD[1:0], bit 0 first on the wire
//   phy2rmii_rx_er   in   RMII RX_ER
//   rmii2mac_rx_clk  out  MII RX clock, 50% duty, free-running
//   rmii2mac_rxd     out  MII RXD nibble
//   rmii2mac_rx_dv   out  MII RX_DV
//   rmii2mac_rx_er   out  MII RX_ER
//   rmii2mac_crs     out  carrier sense
// -----------------------------------------------------------------------------
module rmii_rx_deserializer #(
    parameter int TICK_DIV     = 10,
    parameter int SAMPLE_PHASE = 5
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       speed_100,
    input  logic       phy2rmii_crs_dv,
    input  logic [1:0] phy2rmii_rxd,
    input  logic       phy2rmii_rx_er,
    output logic       rmii2mac_rx_clk,
    output logic [3:0] rmii2mac_rxd,
    output logic       rmii2mac_rx_dv,
    output logic       rmii2mac_rx_er,
    output logic       rmii2mac_crs
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FALSE_CARRIER} state_t;

    // tick marks the ref_clk cycles on which a dibit is sampled
    logic tick;

`ifdef RMII_RX_10M_EN
    localparam logic [3:0] CNT_LAST   = 4'(TICK_DIV - 1);
    localparam logic [3:0] CNT_SAMPLE = 4'(SAMPLE_PHASE);

    logic [3:0] cnt_reg;

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign tick = speed_100 || (cnt_reg == CNT_SAMPLE);
`else
    logic unused_cfg;
    assign unused_cfg = speed_100 ^ (TICK_DIV == SAMPLE_PHASE);
    assign tick       = 1'b1;
`endif

    state_t     state_reg, state_next;
    logic       ph_reg, ph_next;            // rx_clk phase
    logic       hist_reg, hist_next;        // crs_dv on the previous tick
    logic       carrier_reg, carrier_next;  // internal carrier sense
    logic       half_reg, half_next;        // 1 = next dibit is the high half
    logic [1:0] low_reg, low_next;
    logic       low_er_reg, low_er_next;
    logic       nib_valid_reg, nib_valid_next;
    logic [3:0] nib_data_reg, nib_data_next;
    logic       nib_er_reg, nib_er_next;
    logic [3:0] rxd_reg, rxd_next;
    logic       dv_reg, dv_next;
    logic       er_reg, er_next;
    logic       crs_reg, crs_next;
    logic       rise;
    logic       classify;

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ph_reg        <= 1'b0;
            hist_reg      <= 1'b1;  // a frame already running at reset release is ignored
            carrier_reg   <= 1'b0;
            half_reg      <= 1'b0;
            low_reg       <= 2'b00;
            low_er_reg    <= 1'b0;
            nib_valid_reg <= 1'b0;
            nib_data_reg  <= 4'h0;
            nib_er_reg    <= 1'b0;
            rxd_reg       <= 4'h0;
            dv_reg        <= 1'b0;
            er_reg        <= 1'b0;
            crs_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ph_reg        <= ph_next;
            hist_reg      <= hist_next;
            carrier_reg   <= carrier_next;
            half_reg      <= half_next;
            low_reg       <= low_next;
            low_er_reg    <= low_er_next;
            nib_valid_reg <= nib_valid_next;
            nib_data_reg  <= nib_data_next;
            nib_er_reg    <= nib_er_next;
            rxd_reg       <= rxd_next;
            dv_reg        <= dv_next;
            er_reg        <= er_next;
            crs_reg       <= crs_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ph_next        = ph_reg;
        hist_next      = hist_reg;
        carrier_next   = carrier_reg;
        half_next      = half_reg;
        low_next       = low_reg;
        low_er_next    = low_er_reg;
        nib_valid_next = nib_valid_reg;
        nib_data_next  = nib_data_reg;
        nib_er_next    = nib_er_reg;
        rxd_next       = rxd_reg;
        dv_next        = dv_reg;
        er_next        = er_reg;
        crs_next       = crs_reg;
        rise           = phy2rmii_crs_dv && !hist_reg;
        classify       = 1'b0;

        if (tick) begin
            ph_next   = !ph_reg;
            hist_next = phy2rmii_crs_dv;

            // MII outputs move only as rx_clk falls
            if (ph_reg) begin
                crs_next = carrier_reg;
                if (nib_valid_reg) begin
                    rxd_next       = nib_data_reg;
                    dv_next        = 1'b1;
                    er_next        = nib_er_reg;
                    nib_valid_next = 1'b0;
                end else if (state_reg == FALSE_CARRIER) begin
                    rxd_next = 4'hE;
                    dv_next  = 1'b0;
                    er_next  = 1'b1;
                end else begin
                    rxd_next = 4'h0;
                    dv_next  = 1'b0;
                    er_next  = 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    // the rising-edge dibit itself is treated as preamble
                    if (rise) begin
                        carrier_next = 1'b1;
                        classify     = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (!phy2rmii_crs_dv) begin
                        state_next   = IDLE;
                        carrier_next = 1'b0;
                    end else begin
                        classify = 1'b1;
                    end
                end
                FALSE_CARRIER: begin
                    if (!phy2rmii_crs_dv) begin
                        state_next   = IDLE;
                        carrier_next = 1'b0;
                    end
                end
                DATA: begin
                    if (!half_reg) begin
                        // crs_dv on a first dibit is pure carrier sense
                        low_next     = phy2rmii_rxd;
                        low_er_next  = phy2rmii_rx_er;
                        carrier_next = phy2rmii_crs_dv;
                        half_next    = 1'b1;
                    end else begin
                        half_next = 1'b0;
                        if (!phy2rmii_crs_dv) begin
                            // end of frame: unpaired dibit and its error are dropped
                            state_next   = IDLE;
                            carrier_next = 1'b0;
                        end else begin
                            // written after any clear above, so a same-tick refill wins
                            nib_valid_next = 1'b1;
                            nib_data_next  = {phy2rmii_rxd, low_reg};
                            nib_er_next    = low_er_reg | phy2rmii_rx_er;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase

            if (classify) begin
                case (phy2rmii_rxd)
                    2'b01: begin
                        state_next  = DATA;
                        low_next    = phy2rmii_rxd;
                        low_er_next = phy2rmii_rx_er;
                        half_next   = 1'b1;
                    end
                    2'b10:   state_next = FALSE_CARRIER;
                    default: state_next = PREAMBLE;
                endcase
            end
        end
    end

    assign rmii2mac_rx_clk = ph_reg;
    assign rmii2mac_rxd    = rxd_reg;
    assign rmii2mac_rx_dv  = dv_reg;
    assign rmii2mac_rx_er  = er_reg;
    assign rmii2mac_crs    = crs_reg;

endmodule

// File: tb/tb_rmii_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_rmii_rx_deserializer
//
// Drives RMII frames (directed and $urandom-generated) into
// rmii_rx_deserializer and compares the MII nibble stream, sampled on rising
// rx_clk, against a frame-level reference model that pairs dibits from the
// first 01 preamble dibit until CRS_DV is low on a second dibit. Also checks
// reset values, rx_clk period, RX_DV continuity, CRS drop with end toggling,
// false carrier and reset mid-frame. 10 Mb/s frames run when RMII_RX_10M_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_rmii_rx_deserializer;

    localparam int TICK_DIV     = 10;
    localparam int SAMPLE_PHASE = 5;

    logic       ref_clk   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       speed_100 = 1'b1;
    logic       crs_dv    = 1'b0;
    logic [1:0] rxd       = 2'b00;
    logic       rx_er     = 1'b0;
    logic       rx_clk;
    logic [3:0] mii_rxd;
    logic       mii_dv;
    logic       mii_er;
    logic       mii_crs;

    rmii_rx_deserializer #(
        .TICK_DIV     (TICK_DIV),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) dut (
        .ref_clk         (ref_clk),
        .rst_n           (rst_n),
        .speed_100       (speed_100),
        .phy2rmii_crs_dv (crs_dv),
        .phy2rmii_rxd    (rxd),
        .phy2rmii_rx_er  (rx_er),
        .rmii2mac_rx_clk (rx_clk),
        .rmii2mac_rxd    (mii_rxd),
        .rmii2mac_rx_dv  (mii_dv),
        .rmii2mac_rx_er  (mii_er),
        .rmii2mac_crs    (mii_crs)
    );

    always #10 ref_clk = ~ref_clk;

    int vectors     = 0;
    int miscompares = 0;

    // frame under construction: one entry per dibit
    bit       f_dv[$];
    bit [1:0] f_d[$];
    bit       f_er[$];

    // expectation: {er, nibble}
    bit [4:0] exp_q[$];
    bit       exp_fc;
    int       exp_toggles;

    // observation
    bit [4:0] obs_q[$];
    int       dv_runs     = 0;
    int       crs_low     = 0;
    int       fc_seen     = 0;
    int       cyc         = 0;
    int       last_rise   = -1;
    int       last_period = 0;
    bit       prev_rxclk  = 1'b0;
    bit       prev_dv     = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // MAC view: sample on rising rx_clk
    always @(negedge ref_clk) begin
        cyc++;
        if (!rst_n) begin
            prev_rxclk = 1'b0;
            prev_dv    = 1'b0;
            last_rise  = -1;
        end else begin
            if (rx_clk && !prev_rxclk) begin
                if (last_rise >= 0) last_period = cyc - last_rise;
                last_rise = cyc;
                if (mii_dv) begin
                    obs_q.push_back({mii_er, mii_rxd});
                    if (!prev_dv) dv_runs++;
                    if (!mii_crs) crs_low++;
                end else if (mii_er && mii_rxd == 4'hE) begin
                    fc_seen++;
                end
                prev_dv = mii_dv;
            end
            prev_rxclk = rx_clk;
        end
    end

    task automatic clear_obs();
        obs_q.delete();
        dv_runs = 0;
        crs_low = 0;
        fc_seen = 0;
    endtask

    task automatic clear_frame();
        f_dv.delete();
        f_d.delete();
        f_er.delete();
    endtask

    task automatic push_dibit(input bit dv, input bit [1:0] d, input bit er);
        f_dv.push_back(dv);
        f_d.push_back(d);
        f_er.push_back(er);
    endtask

    task automatic push_byte(input bit [7:0] b, input bit [3:0] er_mask);
        for (int k = 0; k < 4; k++) push_dibit(1'b1, b[2*k +: 2], er_mask[k]);
    endtask

    task automatic push_preamble();
        for (int k = 0; k < 7; k++) push_byte(8'h55, 4'h0);
        push_byte(8'hD5, 4'h0);
    endtask

    task automatic exp_preamble();
        exp_q.delete();
        exp_fc      = 1'b0;
        exp_toggles = 0;
        for (int k = 0; k < 14; k++) exp_q.push_back(5'h05);
        exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
    endtask

    // Reference: alignment on first 01 while CRS_DV high (10 first = false
    // carrier), then pair dibits until CRS_DV is low on a second dibit.
    task automatic run_model();
        int n;
        int s;
        n = f_dv.size();
        s = -1;
        exp_q.delete();
        exp_fc      = 1'b0;
        exp_toggles = 0;
        for (int i = 0; i < n; i++) begin
            if (!f_dv[i]) break;
            if (f_d[i] == 2'b01) begin s = i; break; end
            if (f_d[i] == 2'b10) begin exp_fc = 1'b1; break; end
        end
        if (s >= 0) begin
            for (int j = s; j + 1 < n; j += 2) begin
                if (!f_dv[j+1]) break;
                exp_q.push_back({f_er[j] | f_er[j+1], f_d[j+1], f_d[j]});
                if (!f_dv[j]) exp_toggles++;
            end
        end
    endtask

    task automatic send_dibit(input bit dv, input bit [1:0] d, input bit er);
        int hold;
        hold = speed_100 ? 1 : TICK_DIV;
        @(negedge ref_clk);
        crs_dv = dv;
        rxd    = d;
        rx_er  = er;
        repeat (hold - 1) @(negedge ref_clk);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_dibit(f_dv[i], f_d[i], f_er[i]);
    endtask

    task automatic finish_frame(input string name);
        int n;
        repeat (8) send_dibit(1'b0, 2'b00, 1'b0);
        n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
        check_val($sformatf("%s_count", name), obs_q.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            check_val($sformatf("%s_nib%0d", name, i), int'(obs_q[i]), int'(exp_q[i]));
        check_val($sformatf("%s_dv_runs", name), dv_runs, (exp_q.size() > 0) ? 1 : 0);
        check_val($sformatf("%s_crs_low_min", name), int'(crs_low >= exp_toggles), 1);
        check_val($sformatf("%s_crs_low_max", name), int'(crs_low <= exp_toggles + 1), 1);
        check_val($sformatf("%s_false_carrier", name), int'(fc_seen > 0), int'(exp_fc));
        check_val($sformatf("%s_rxclk_period", name), last_period, speed_100 ? 2 : 2 * TICK_DIV);
        check_val($sformatf("%s_idle_dv", name), int'(mii_dv), 0);
        $display("frame %s: speed100=%0d expected %0d nibbles, observed %0d, crs_low %0d, fc %0d",
                 name, speed_100, exp_q.size(), obs_q.size(), crs_low, fc_seen);
    endtask

    task automatic play(input string name);
        clear_obs();
        send_range(0, f_dv.size());
        finish_frame(name);
    endtask

    task automatic test_basic(input string name);
        clear_frame();
        push_preamble();
        push_byte(8'hA1, 4'h0);
        push_byte(8'h3C, 4'h0);
        push_dibit(1'b0, 2'b00, 1'b0);
        exp_preamble();
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h0A);
        exp_q.push_back(5'h0C);
        exp_q.push_back(5'h03);
        play(name);
    endtask

    task automatic random_frame(input int idx);
        int kind;
        int style;
        kind = $urandom_range(0, 9);
        clear_frame();
        repeat ($urandom_range(0, 3)) push_dibit(1'b1, 2'b00, 1'b0);
        if (kind == 0) begin
            push_dibit(1'b1, 2'b10, 1'b0);
            repeat ($urandom_range(1, 4)) push_dibit(1'b1, 2'($urandom), 1'b0);
        end else if (kind == 1) begin
            push_dibit(1'b1, 2'b00, 1'b0);
        end else begin
            repeat ($urandom_range(1, 7)) push_byte(8'h55, 4'h0);
            push_byte(8'hD5, 4'h0);
            repeat ($urandom_range(1, 6))
                push_byte(8'($urandom),
                          ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0);
            style = $urandom_range(0, 2);
            if (style == 1) begin
                repeat ($urandom_range(1, 2)) begin
                    push_dibit(1'b0, 2'($urandom), 1'b0);
                    push_dibit(1'b1, 2'($urandom), 1'($urandom));
                end
            end else if (style == 2) begin
                push_dibit(1'b1, 2'($urandom), 1'($urandom));
            end
        end
        push_dibit(1'b0, 2'($urandom), 1'($urandom));
        push_dibit(1'b0, 2'b00, 1'b0);
        run_model();
        play($sformatf("rnd%0d", idx));
    endtask

    initial begin
        repeat (4) @(negedge ref_clk);
        check_val("reset_rx_clk", int'(rx_clk), 0);
        check_val("reset_rxd", int'(mii_rxd), 0);
        check_val("reset_dv", int'(mii_dv), 0);
        check_val("reset_er", int'(mii_er), 0);
        check_val("reset_crs", int'(mii_crs), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge ref_clk);

        test_basic("basic_100m");

        // end-of-frame toggling with two 0xF nibbles
        clear_frame();
        push_preamble();
        push_byte(8'hA1, 4'h0);
        for (int k = 0; k < 2; k++) begin
            push_dibit(1'b0, 2'b11, 1'b0);
            push_dibit(1'b1, 2'b11, 1'b0);
        end
        push_dibit(1'b0, 2'b00, 1'b0);
        push_dibit(1'b0, 2'b00, 1'b0);
        exp_preamble();
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h0A);
        exp_q.push_back(5'h0F);
        exp_q.push_back(5'h0F);
        exp_toggles = 2;
        play("toggle_end");

        // false carrier
        clear_frame();
        push_dibit(1'b1, 2'b00, 1'b0);
        push_dibit(1'b1, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) push_dibit(1'b1, 2'b10, 1'b0);
        push_dibit(1'b0, 2'b00, 1'b0);
        exp_q.delete();
        exp_fc      = 1'b1;
        exp_toggles = 0;
        play("false_carrier");

        // rx_er on the second dibit of 0x77
        clear_frame();
        push_preamble();
        push_byte(8'h77, 4'b0010);
        push_byte(8'h12, 4'h0);
        push_dibit(1'b0, 2'b00, 1'b0);
        exp_preamble();
        exp_q.push_back(5'h17);
        exp_q.push_back(5'h07);
        exp_q.push_back(5'h02);
        exp_q.push_back(5'h01);
        play("rx_er_077");

        // one-cycle reset in the middle of DATA with crs_dv held high
        clear_frame();
        push_preamble();
        for (int k = 0; k < 6; k++) push_byte(8'($urandom), 4'h0);
        push_dibit(1'b0, 2'b00, 1'b0);
        clear_obs();
        send_range(0, 40);
        @(negedge ref_clk);
        rst_n = 1'b0;
        @(negedge ref_clk);
        check_val("midrst_rxd", int'(mii_rxd), 0);
        check_val("midrst_dv", int'(mii_dv), 0);
        check_val("midrst_er", int'(mii_er), 0);
        check_val("midrst_crs", int'(mii_crs), 0);
        check_val("midrst_rx_clk", int'(rx_clk), 0);
        rst_n = 1'b1;
        clear_obs();
        send_range(40, f_dv.size());
        exp_q.delete();
        exp_fc      = 1'b0;
        exp_toggles = 0;
        finish_frame("after_reset");
        test_basic("post_reset_frame");

        for (int i = 0; i < 30; i++) random_frame(i);

`ifdef RMII_RX_10M_EN
        speed_100 = 1'b0;
        repeat (3 * TICK_DIV) @(negedge ref_clk);
        test_basic("basic_10m");
        for (int i = 0; i < 5; i++) random_frame(100 + i);
        speed_100 = 1'b1;
        repeat (4) @(negedge ref_clk);
        test_basic("back_to_100m");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
